// File: rtl/force_release_seq_if.sv
// Command channel for force_release_seq: valid/ready handshake carrying
// an opcode, a target element index and a force value.
interface force_release_seq_if #(
    parameter int IW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_idx;
    logic          cmd_val;

    // The command source drives the payload and valid, and watches ready.
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_idx,
        output cmd_val,
        input  cmd_ready
    );

    // The controller consumes the payload and reports whether it can accept.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_idx,
        input  cmd_val,
        output cmd_ready
    );
endinterface

// File: rtl/force_release_seq.sv
// Sequenced force/release controller for an N-element signal array.
// Per-element commands arrive through a small FIFO; a rising edge of en
// freezes every element at the current i_a, a falling edge releases all.
// o_a and force_mask are registered and always change on the same edge.
module force_release_seq #(
    parameter int N     = 8,
    parameter int IW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    force_release_seq_if.slave   cmd,
    input  logic                 en,
    input  logic                 i_a,
    output logic [N-1:0]         o_a,
    output logic [N-1:0]         force_mask,
    output logic                 busy,
    output logic                 err
);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    // Index limit held one bit wider than the index so that N itself fits.
    localparam logic [IW:0]     IDX_LIM  = (IW + 1)'(N);

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_FORCE   = 2'b01,
        OP_RELEASE = 2'b10,
        OP_REL_ALL = 2'b11
    } op_e;

    typedef struct packed {
        op_e           op;
        logic [IW-1:0] idx;
        logic          val;
    } cmd_t;

    // Command storage (payload only, never reset)
    cmd_t          mem_q [DEPTH];

    // Queue control
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ready_q,  ready_d;
    logic          busy_q,   busy_d;

    // Force state and outputs
    logic          en_q;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  val_q,  val_d;
    logic [N-1:0]  o_a_q,  o_a_d;
    logic          err_q,  err_d;

    logic          push;
    logic          pop;
    logic          rise;
    logic          fall;
    logic          head_oob;
    cmd_t          head;

    assign head     = mem_q[rd_ptr_q];
    assign push     = cmd.cmd_valid && ready_q;
    assign rise     = en && !en_q;
    assign fall     = !en && en_q;
    // An en edge owns the cycle; the queue head waits for the next one.
    assign pop      = !rise && !fall && (count_q != '0);
    assign head_oob = ({1'b0, head.idx} >= IDX_LIM);

    // Queue pointer and occupancy bookkeeping; ready/busy are registered
    // copies of the next occupancy so they line up with count_q.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
        busy_d  = (count_d != '0);
    end

    // Select the single action for this cycle: rise, fall, or queue head,
    // then form the next effective array from the next mask and values.
    always_comb begin
        mask_d = mask_q;
        val_d  = val_q;
        err_d  = err_q;
        o_a_d  = '0;
        if (rise) begin
            mask_d = '1;
            val_d  = {N{i_a}};
        end else if (fall) begin
            mask_d = '0;
        end else if (pop) begin
            case (head.op)
                OP_FORCE: begin
                    if (head_oob) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (head.idx == IW'(i)) begin
                                mask_d[i] = 1'b1;
                                val_d[i]  = head.val;
                            end
                        end
                    end
                end
                OP_RELEASE: begin
                    if (head_oob) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (head.idx == IW'(i)) begin
                                mask_d[i] = 1'b0;
                            end
                        end
                    end
                end
                OP_REL_ALL: begin
                    mask_d = '0;
                end
                default: begin
                    mask_d = mask_q;
                end
            endcase
        end
        for (int i = 0; i < N; i++) begin
            o_a_d[i] = mask_d[i] ? val_d[i] : i_a;
        end
    end

    // Write accepted commands at the tail of the queue.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'({cmd.cmd_op, cmd.cmd_idx, cmd.cmd_val});
        end
    end

    // Queue control registers; reset discards anything still queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Force state, edge-detect history and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            mask_q <= '0;
            val_q  <= '0;
            o_a_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            en_q   <= en;
            mask_q <= mask_d;
            val_q  <= val_d;
            o_a_q  <= o_a_d;
            err_q  <= err_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign force_mask    = mask_q;
    assign o_a           = o_a_q;
endmodule

// File: tb/tb_force_release_seq.sv
// Directed bench for force_release_seq with a reference model: accepted
// commands are pushed into a scoreboard queue and popped when the model
// says the DUT applies them; every cycle the outputs are compared.
module tb_force_release_seq;
    localparam int N     = 8;
    localparam int IW    = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         i_a = 1'b0;
    logic [N-1:0] o_a;
    logic [N-1:0] force_mask;
    logic         busy;
    logic         err;

    force_release_seq_if #(.IW(IW)) cmd_if ();

    force_release_seq #(.N(N), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .en         (en),
        .i_a        (i_a),
        .o_a        (o_a),
        .force_mask (force_mask),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [IW-1:0] idx;
        logic          val;
    } tcmd_t;

    tcmd_t        sb_q[$];
    logic [N-1:0] m_mask, m_val, m_oa;
    logic         m_err, m_en_q, m_ready, m_busy;
    int           n_assert = 0;
    int           n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dir(input string tag, input logic [N-1:0] exp_mask, input logic [N-1:0] exp_oa);
        check({tag, "_mask"}, 32'(force_mask), 32'(exp_mask));
        check({tag, "_oa"},   32'(o_a),        32'(exp_oa));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_mask  = '0;
        m_val   = '0;
        m_oa    = '0;
        m_err   = 1'b0;
        m_en_q  = 1'b0;
        m_ready = 1'b1;
        m_busy  = 1'b0;
    endtask

    // One clock: predict from the inputs present now, clock, then compare.
    task automatic cycle();
        logic         rise, fall, acc;
        logic [N-1:0] bit_m;
        tcmd_t        h, c;
        acc  = cmd_if.cmd_valid && m_ready;
        rise = en && !m_en_q;
        fall = !en && m_en_q;
        if (rise) begin
            m_mask = '1;
            m_val  = {N{i_a}};
        end else if (fall) begin
            m_mask = '0;
        end else if (sb_q.size() > 0) begin
            h     = sb_q.pop_front();
            bit_m = N'(1) << h.idx;
            if ((h.op == 2'b01 || h.op == 2'b10) && int'(h.idx) >= N) begin
                m_err = 1'b1;
            end else if (h.op == 2'b01) begin
                m_mask = m_mask | bit_m;
                m_val  = (m_val & ~bit_m) | ({N{h.val}} & bit_m);
            end else if (h.op == 2'b10) begin
                m_mask = m_mask & ~bit_m;
            end else if (h.op == 2'b11) begin
                m_mask = '0;
            end
        end
        if (acc) begin
            c.op  = cmd_if.cmd_op;
            c.idx = cmd_if.cmd_idx;
            c.val = cmd_if.cmd_val;
            sb_q.push_back(c);
        end
        m_oa    = (m_mask & m_val) | (~m_mask & {N{i_a}});
        m_en_q  = en;
        m_ready = (sb_q.size() != DEPTH);
        m_busy  = (sb_q.size() != 0);
        @(posedge clk);
        @(negedge clk);
        check("cyc_oa",    32'(o_a),              32'(m_oa));
        check("cyc_mask",  32'(force_mask),       32'(m_mask));
        check("cyc_err",   32'(err),              32'(m_err));
        check("cyc_ready", 32'(cmd_if.cmd_ready), 32'(m_ready));
        check("cyc_busy",  32'(busy),             32'(m_busy));
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input int idx, input logic val);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_idx   = IW'(idx);
        cmd_if.cmd_val   = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive(1'b0, 2'b00, 0, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_oa",    32'(o_a),              32'h0);
        check("rst_mask",  32'(force_mask),       32'h0);
        check("rst_busy",  32'(busy),             32'h0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
        check("rst_err",   32'(err),              32'h0);
        rst = 1'b0;

        // Live source fans out to every unforced element.
        i_a = 1'b1;
        cycle();
        chk_dir("live", 8'h00, 8'hFF);

        // Single-element force then release.
        drive(1'b1, 2'b01, 3, 1'b0);
        cycle();
        drive(1'b0, 2'b00, 0, 1'b0);
        cycle();
        chk_dir("force3", 8'h08, 8'hF7);
        drive(1'b1, 2'b10, 3, 1'b0);
        cycle();
        drive(1'b0, 2'b00, 0, 1'b0);
        cycle();
        chk_dir("rel3", 8'h00, 8'hFF);

        // Group freeze on en rise, release on en fall.
        en = 1'b1;
        cycle();
        chk_dir("rise", 8'hFF, 8'hFF);
        i_a = 1'b0;
        cycle();
        cycle();
        chk_dir("frozen", 8'hFF, 8'hFF);
        en = 1'b0;
        cycle();
        chk_dir("fall", 8'h00, 8'h00);

        // Out-of-range index sets sticky err and changes nothing.
        drive(1'b1, 2'b01, 8, 1'b1);
        cycle();
        drive(1'b0, 2'b00, 0, 1'b0);
        cycle();
        check("oob_err", 32'(err), 32'h1);
        chk_dir("oob", 8'h00, 8'h00);
        cycle();
        cycle();
        check("oob_sticky", 32'(err), 32'h1);
        drive(1'b1, 2'b01, 5, 1'b1);
        cycle();
        drive(1'b1, 2'b10, 9, 1'b0);
        cycle();
        drive(1'b0, 2'b00, 0, 1'b0);
        cycle();
        chk_dir("after_oob", 8'h20, 8'h20);
        check("oob_sticky2", 32'(err), 32'h1);
        drive(1'b1, 2'b11, 0, 1'b0);
        cycle();
        drive(1'b0, 2'b00, 0, 1'b0);
        cycle();
        chk_dir("relall", 8'h00, 8'h00);

        // Fill the queue while en toggles every cycle, blocking pops.
        drive(1'b1, 2'b01, 1, 1'b1); en = 1'b1; cycle();
        drive(1'b1, 2'b01, 3, 1'b1); en = 1'b0; cycle();
        drive(1'b1, 2'b01, 4, 1'b1); en = 1'b1; cycle();
        drive(1'b1, 2'b01, 6, 1'b1); en = 1'b0; cycle();
        check("full_ready", 32'(cmd_if.cmd_ready), 32'h0);
        check("full_busy",  32'(busy),             32'h1);
        chk_dir("full", 8'h00, 8'h00);
        // en now stable: drain in order while a held command waits for space.
        drive(1'b1, 2'b01, 0, 1'b1);
        cycle();
        chk_dir("drain1", 8'h02, 8'h02);
        cycle();
        chk_dir("drain2", 8'h0A, 8'h0A);
        drive(1'b1, 2'b01, 2, 1'b1);
        cycle();
        chk_dir("drain3", 8'h1A, 8'h1A);
        drive(1'b1, 2'b01, 5, 1'b1);
        cycle();
        chk_dir("drain4", 8'h5A, 8'h5A);
        drive(1'b0, 2'b00, 0, 1'b0);
        check("pre_rst_busy", 32'(busy), 32'h1);

        // Asynchronous reset with three commands still queued.
        #1 rst = 1'b1;
        #1;
        check("arst_oa",    32'(o_a),              32'h0);
        check("arst_mask",  32'(force_mask),       32'h0);
        check("arst_busy",  32'(busy),             32'h0);
        check("arst_err",   32'(err),              32'h0);
        check("arst_ready", 32'(cmd_if.cmd_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        i_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
        end
        chk_dir("post_rst", 8'h00, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
